cdc_xfer_arbiter: RTL and testbench

- Source-side controller that shares one multi-bit clock-domain-crossing word channel between NUM_REQ requesters.
- Picks a requester round-robin and loads its word onto the crossing bus.
- Holds the word stable for HOLD_CYCLES, then flips a request toggle.
- Waits for the destination's ack toggle, already brought back into sys_clk by an external 2-FF synchronizer, before granting again.
- Sits between producer blocks and the 2-flop CDC datapath; the datapath's data register is driven by cdc_data.

---
 rtl/cdc_xfer_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/cdc_xfer_arbiter.sv | 134 +++++++++++++
 tb/tb_cdc_xfer_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_xfer_pkg.sv
// Shared state encoding, defaults and elaboration helpers for the CDC
// word-transfer arbiter.
package cdc_xfer_pkg;

    localparam logic [1:0] ENC_IDLE     = 2'd0;
    localparam logic [1:0] ENC_HOLD     = 2'd1;
    localparam logic [1:0] ENC_WAIT_ACK = 2'd2;
    localparam logic [1:0] ENC_ERROR    = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ENC_IDLE,
        HOLD     = ENC_HOLD,
        WAIT_ACK = ENC_WAIT_ACK,
        ERROR    = ENC_ERROR
    } xfer_state_e;

    localparam int HOLD_CYCLES_DEF = 3;
    localparam int TIMEOUT_DEF     = 255;

    // Ceiling log2; clog2(1) is 0, so callers needing a real counter clamp to 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant wins,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import cdc_xfer_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int   cand;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (enable && !found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Shares one toggle-handshake CDC word channel between NUM_REQ producers,
// granting round-robin and holding each word stable before the request toggle.
//
// state    | meaning
// IDLE     | channel free, arbitrating among req_valid
// HOLD     | word loaded on cdc_data, counting down before the toggle flips
// WAIT_ACK | toggle flipped, waiting for the synchronized ack toggle to match
// ERROR    | ack timed out; leaves only on err_clr once the toggles agree
module cdc_xfer_arbiter
    import cdc_xfer_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 64,
    parameter int TAG_W       = 2,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         cdc_data,
    output logic [TAG_W-1:0]          cdc_tag,
    output logic                      cdc_req_tgl,
    input  logic                      cdc_ack_tgl,
    output logic                      busy,
    output logic                      timeout_err,
    input  logic                      err_clr
);

    localparam int HOLD_W = (clog2(HOLD_CYCLES + 1) > 0) ? clog2(HOLD_CYCLES + 1) : 1;
    localparam int TO_W   = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [TO_W-1:0]   TO_SAT    = {TO_W{1'b1}};

    xfer_state_e       state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [TAG_W-1:0]  last_grant;

    logic              arb_enable;
    logic [NUM_REQ-1:0] win_onehot;
    logic [TAG_W-1:0]  win_idx;
    logic              win_any;
    logic [DATA_W-1:0] win_word;
    logic              ack_match;

    // Gated by reset too, so an asserted reset forces every output low at once.
    assign arb_enable = (state == IDLE) && sys_rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (TAG_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (arb_enable),
        .grant      (win_onehot),
        .grant_idx  (win_idx)
    );

    assign win_any   = |win_onehot;
    assign req_ready = win_onehot;
    assign ack_match = (cdc_ack_tgl == cdc_req_tgl);

    always_comb begin
        win_word = req_data[int'(win_idx)*DATA_W +: DATA_W];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cdc_data    <= '0;
            cdc_tag     <= '0;
            cdc_req_tgl <= 1'b0;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            last_grant  <= TAG_W'(NUM_REQ - 1);
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        cdc_data   <= win_word;
                        cdc_tag    <= win_idx;
                        last_grant <= win_idx;
                        hold_cnt   <= HOLD_INIT;
                        busy       <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == HOLD_W'(1)) begin
                        cdc_req_tgl <= ~cdc_req_tgl;
                        to_cnt      <= '0;
                        state       <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A matching ack wins even on the cycle the timeout would fire.
                    if (ack_match) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (to_cnt != TO_SAT) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                        if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
                            timeout_err <= 1'b1;
                            state       <= ERROR;
                        end
                    end
                end
                ERROR: begin
                    // A still-pending ack must land here, not on the next transfer.
                    if (err_clr && ack_match) begin
                        timeout_err <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Self-checking bench for cdc_xfer_arbiter: scenario tasks plus randomized
// traffic compared against a transaction-level round-robin model.
module tb_cdc_xfer_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 64;
    localparam int TAG_W       = 2;
    localparam int HOLD_CYCLES = 3;
    localparam int TIMEOUT     = 16;

    logic                      sys_clk = 1'b0;
    logic                      sys_rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         cdc_data;
    logic [TAG_W-1:0]          cdc_tag;
    logic                      cdc_req_tgl;
    logic                      cdc_ack_tgl;
    logic                      busy;
    logic                      timeout_err;
    logic                      err_clr;

    logic [DATA_W-1:0] word_q [NUM_REQ];

    int checks = 0;
    int errors = 0;

    int                model_last;
    logic              model_tgl;
    logic [DATA_W-1:0] cur_word;
    int                cur_tag;

    cdc_xfer_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TAG_W       (TAG_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .cdc_data    (cdc_data),
        .cdc_tag     (cdc_tag),
        .cdc_req_tgl (cdc_req_tgl),
        .cdc_ack_tgl (cdc_ack_tgl),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = word_q[i];
        end
    end

    // Reference rule: first valid index after the previous winner, wrapping.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (last + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid   = '0;
        err_clr     = 1'b0;
        cdc_ack_tgl = 1'b0;
        sys_rst_n   = 1'b0;
        tick();
        tick();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        model_last = NUM_REQ - 1;
        model_tgl  = 1'b0;
    endtask

    // Accept + hold phase; returns after the toggle flip with the DUT in WAIT_ACK.
    task automatic start_xfer(output int w);
        logic [NUM_REQ-1:0] exp_rdy;
        #1;
        w = rr_pick(req_valid, model_last);
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL accept_ready got %b want %b", req_ready, exp_rdy);
        end
        if (w < 0) return;
        cur_word = word_q[w];
        cur_tag  = w;
        tick();
        model_last = w;
        checks++;
        if (cdc_tag !== TAG_W'(w) || cdc_data !== cur_word) begin
            errors++;
            $display("FAIL accept_word got tag %0d data %h want tag %0d data %h", cdc_tag, cdc_data, w, cur_word);
        end
        for (int k = 1; k <= HOLD_CYCLES; k++) begin
            checks++;
            if (busy !== 1'b1 || req_ready !== '0 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_state got busy %b ready %b err %b want 1 0000 0", busy, req_ready, timeout_err);
            end
            checks++;
            if (cdc_data !== cur_word || cdc_tag !== TAG_W'(cur_tag)) begin
                errors++;
                $display("FAIL hold_data got %h want %h", cdc_data, cur_word);
            end
            checks++;
            if (cdc_req_tgl !== model_tgl) begin
                errors++;
                $display("FAIL hold_tgl got %b want %b at hold cycle %0d", cdc_req_tgl, model_tgl, k);
            end
            tick();
        end
        model_tgl = ~model_tgl;
        checks++;
        if (cdc_req_tgl !== model_tgl) begin
            errors++;
            $display("FAIL flip_tgl got %b want %b", cdc_req_tgl, model_tgl);
        end
    endtask

    // Ack arrives d cycles after the flip; busy must drop on the following edge.
    task automatic finish_ack(input int d);
        for (int i = 0; i <= d; i++) begin
            checks++;
            if (busy !== 1'b1 || timeout_err !== 1'b0 || req_ready !== '0 || cdc_data !== cur_word) begin
                errors++;
                $display("FAIL wait_state got busy %b err %b ready %b data %h want 1 0 0000 %h", busy, timeout_err, req_ready, cdc_data, cur_word);
            end
            if (i < d) tick();
        end
        cdc_ack_tgl = model_tgl;
        tick();
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || cdc_req_tgl !== model_tgl || cdc_data !== cur_word) begin
            errors++;
            $display("FAIL ack_done got busy %b err %b tgl %b data %h want 0 0 %b %h", busy, timeout_err, cdc_req_tgl, cdc_data, model_tgl, cur_word);
        end
    endtask

    task automatic test_reset();
        sys_rst_n   = 1'b0;
        req_valid   = '0;
        err_clr     = 1'b0;
        cdc_ack_tgl = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) word_q[i] = '0;
        #2;
        checks++;
        if (cdc_data !== '0 || cdc_tag !== '0 || cdc_req_tgl !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_outputs got data %h tag %0d tgl %b busy %b err %b ready %b want all zero", cdc_data, cdc_tag, cdc_req_tgl, busy, timeout_err, req_ready);
        end
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_ready !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_req got ready %b busy %b want 0000 0", req_ready, busy);
            end
            tick();
        end
    endtask

    task automatic test_single();
        int w;
        word_q[2]    = 64'hDEADBEEF_00000001;
        req_valid    = 4'b0100;
        start_xfer(w);
        req_valid = '0;
        checks++;
        if (w !== 2 || cdc_tag !== 2'd2 || cdc_data !== 64'hDEADBEEF_00000001) begin
            errors++;
            $display("FAIL single_tag got %0d data %h want 2 deadbeef00000001", cdc_tag, cdc_data);
        end
        finish_ack(5);
    endtask

    task automatic test_ack_beats_timeout();
        int w;
        word_q[1] = rand_word();
        req_valid = 4'b0010;
        start_xfer(w);
        req_valid = '0;
        finish_ack(TIMEOUT - 1);
    endtask

    task automatic test_timeout();
        int w;
        word_q[3] = rand_word();
        req_valid = 4'b1000;
        start_xfer(w);
        req_valid = 4'b0100;
        for (int e = 1; e <= TIMEOUT; e++) begin
            tick();
            checks++;
            if (timeout_err !== (e == TIMEOUT) || busy !== 1'b1 || req_ready !== '0) begin
                errors++;
                $display("FAIL timeout_edge got err %b busy %b ready %b want err %b at cycle %0d", timeout_err, busy, req_ready, (e == TIMEOUT), e);
            end
        end
        req_valid = '0;
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b1 || cdc_data !== cur_word) begin
            errors++;
            $display("FAIL clr_ignored got err %b busy %b want 1 1", timeout_err, busy);
        end
        cdc_ack_tgl = model_tgl;
        tick();
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL err_needs_clr got %b want 1", timeout_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_accepted got err %b busy %b want 0 0", timeout_err, busy);
        end
    endtask

    task automatic test_drop_valid();
        int w;
        word_q[0] = rand_word();
        word_q[1] = rand_word();
        word_q[3] = rand_word();
        req_valid = 4'b0001;
        start_xfer(w);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1000;
        finish_ack(4);
        start_xfer(w);
        req_valid = '0;
        checks++;
        if (w !== 3 || cdc_tag !== 2'd3) begin
            errors++;
            $display("FAIL dropped_req got tag %0d want 3", cdc_tag);
        end
        finish_ack(0);
    endtask

    task automatic test_fairness();
        int w;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) word_q[i] = rand_word();
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            start_xfer(w);
            word_q[w] = rand_word();
            checks++;
            if (cdc_tag !== TAG_W'(i % NUM_REQ) || cdc_req_tgl !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL fair_order got tag %0d tgl %b want %0d %b", cdc_tag, cdc_req_tgl, i % NUM_REQ, ((i % 2) == 0));
            end
            finish_ack(2);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        int w;
        logic [NUM_REQ-1:0] nv;
        for (int n = 0; n < 24; n++) begin
            nv = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (nv[i] && !req_valid[i]) word_q[i] = rand_word();
            end
            req_valid = nv;
            start_xfer(w);
            if (w >= 0) req_valid[w] = 1'b0;
            finish_ack(int'($urandom_range(0, TIMEOUT - 1)));
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        int w;
        word_q[0] = 64'h55;
        req_valid = 4'b0001;
        #1;
        tick();
        checks++;
        if (cdc_data !== 64'h55 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got data %h busy %b want 55 1", cdc_data, busy);
        end
        tick();
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (cdc_data !== '0 || cdc_tag !== '0 || cdc_req_tgl !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL async_reset got data %h tag %0d tgl %b busy %b err %b ready %b want all zero", cdc_data, cdc_tag, cdc_req_tgl, busy, timeout_err, req_ready);
        end
        req_valid   = '0;
        cdc_ack_tgl = 1'b0;
        tick();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        model_last = NUM_REQ - 1;
        model_tgl  = 1'b0;
        word_q[0]  = rand_word();
        word_q[2]  = rand_word();
        req_valid  = 4'b0101;
        start_xfer(w);
        req_valid[0] = 1'b0;
        checks++;
        if (w !== 0 || cdc_tag !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_prio got tag %0d want 0", cdc_tag);
        end
        finish_ack(1);
        start_xfer(w);
        req_valid = '0;
        finish_ack(3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_ack_beats_timeout();
        test_timeout();
        test_drop_valid();
        test_fairness();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
